// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: PC redirect resolution, data-memory
// access over a req/ack handshake with timeout, and the registered MEM/WB fields.
module mem_access_stage #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_MEM,
    input  logic              rst_n_MEM,
    input  logic [7:0]        resAdd1_MEM_IN,
    input  logic              zf_MEM_IN,
    input  logic [31:0]       resALU_MEM_IN,
    input  logic [31:0]       concatenador_MEM_IN,
    input  logic [31:0]       regData2_MEM_IN,
    input  logic [4:0]        mux2Output_MEM_IN,
    input  logic [1:0]        WB_MEM_IN,
    input  logic              branch_MEM_IN,
    input  logic              MemRead_MEM_IN,
    input  logic              MemWrite_MEM_IN,
    input  logic              jump_MEM_IN,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_MEM,
    output logic [1:0]        pcSrc_MEM,
    output logic [31:0]       pcTarget_MEM,
    output logic [1:0]        WB_MEM,
    output logic [31:0]       readData_MEM,
    output logic [31:0]       resALU_MEM,
    output logic [4:0]        mux2Output_MEM,
    output logic              err_MEM
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req, r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_err;
    logic [1:0]         r_wb;
    logic [31:0]        r_rdata, r_res;
    logic [4:0]         r_rd;

    logic               w_acc, w_aligned;
    logic               w_start, w_done, w_abort, w_misal;
    logic [1:0]         w_wb;
    logic [31:0]        w_rdata, w_res;
    logic [4:0]         w_rd;

    assign w_acc     = MemRead_MEM_IN | MemWrite_MEM_IN;
    assign w_aligned = (resALU_MEM_IN[1:0] == 2'b00);

    always_comb begin
        w_next       = r_state;
        stall_MEM    = 1'b0;
        pcSrc_MEM    = 2'b00;
        pcTarget_MEM = '0;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        w_misal      = 1'b0;
        w_wb         = 2'b00;
        w_res        = '0;
        w_rd         = '0;
        w_rdata      = '0;
        case (r_state)
            S_IDLE: begin
                if (jump_MEM_IN) begin
                    pcSrc_MEM    = 2'b10;
                    pcTarget_MEM = concatenador_MEM_IN;
                end else if (branch_MEM_IN && zf_MEM_IN) begin
                    pcSrc_MEM    = 2'b01;
                    pcTarget_MEM = {24'b0, resAdd1_MEM_IN};
                end
                if (w_acc && w_aligned) begin
                    w_start   = 1'b1;
                    stall_MEM = 1'b1;
                    w_next    = S_WAIT;
                end else if (w_acc) begin
                    // misaligned: pass the instruction through but suppress write-back
                    w_misal = 1'b1;
                    w_res   = resALU_MEM_IN;
                    w_rd    = mux2Output_MEM_IN;
                end else begin
                    w_wb  = WB_MEM_IN;
                    w_res = resALU_MEM_IN;
                    w_rd  = mux2Output_MEM_IN;
                end
            end
            S_WAIT: begin
                // ack wins over a coincident timeout
                if (dmem_ack) begin
                    w_next  = S_IDLE;
                    w_done  = 1'b1;
                    w_wb    = WB_MEM_IN;
                    w_res   = resALU_MEM_IN;
                    w_rd    = mux2Output_MEM_IN;
                    w_rdata = r_we ? 32'h0 : dmem_rdata;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_next  = S_IDLE;
                    w_abort = 1'b1;
                    w_res   = resALU_MEM_IN;
                    w_rd    = mux2Output_MEM_IN;
                end else begin
                    stall_MEM = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_MEM or negedge rst_n_MEM) begin
        if (!rst_n_MEM) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start)
                r_cnt <= '0;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Request fields stay frozen for the whole WAIT period
    always_ff @(posedge clk_MEM or negedge rst_n_MEM) begin
        if (!rst_n_MEM) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= MemWrite_MEM_IN;
            r_addr  <= resALU_MEM_IN[ADDR_W+1:2];
            r_wdata <= regData2_MEM_IN;
        end else if (w_done || w_abort) begin
            r_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk_MEM or negedge rst_n_MEM) begin
        if (!rst_n_MEM)
            r_err <= 1'b0;
        else if ((w_start && MemRead_MEM_IN && MemWrite_MEM_IN) || w_misal || w_abort)
            r_err <= 1'b1;
    end

    always_ff @(posedge clk_MEM or negedge rst_n_MEM) begin
        if (!rst_n_MEM) begin
            r_wb    <= 2'b00;
            r_rdata <= '0;
            r_res   <= '0;
            r_rd    <= '0;
        end else begin
            r_wb    <= w_wb;
            r_rdata <= w_rdata;
            r_res   <= w_res;
            r_rd    <= w_rd;
        end
    end

    assign dmem_req       = r_req;
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign err_MEM        = r_err;
    assign WB_MEM         = r_wb;
    assign readData_MEM   = r_rdata;
    assign resALU_MEM     = r_res;
    assign mux2Output_MEM = r_rd;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the 5-stage MIPS pipeline, on the consumer side of the EX/MEM pipeline register (BF2). It takes the latched EX/MEM fields and control bits, resolves the branch/jump PC redirect, and runs data loads and stores against an external variable-latency data memory through a req/ack handshake. Upstream is stalled while an access is outstanding. It produces the registered MEM/WB fields for the write-back stage.

## Interface
- ADDR_W, 8, data-memory word-address width; dmem_addr = resALU[ADDR_W+1:2]
- TIMEOUT, 16, maximum WAIT cycles without dmem_ack before abort (≥2)

- clk_MEM  in  1  clock; all state on rising edge
- rst_n_MEM  in  1  reset; one clock, reset asynchronous active-low
- resAdd1_MEM_IN  in  8  branch target PC
- zf_MEM_IN  in  1  ALU zero flag
- resALU_MEM_IN  in  32  ALU result / memory byte address
- concatenador_MEM_IN  in  32  jump target
- regData2_MEM_IN  in  32  store data
- mux2Output_MEM_IN  in  5  destination register
- WB_MEM_IN  in  2  write-back control
- branch_MEM_IN, MemRead_MEM_IN, MemWrite_MEM_IN, jump_MEM_IN  in  1 each  M control
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  ADDR_W  word address, registered
- dmem_wdata  out  32  store data, registered
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  load data, valid with dmem_ack
- stall_MEM  out  1  hold BF2 and earlier stages (combinational)
- pcSrc_MEM  out  2  00 sequential, 01 branch, 10 jump (combinational)
- pcTarget_MEM  out  32  redirect target (combinational)
- WB_MEM  out  2  registered write-back control
- readData_MEM  out  32  registered load data
- resALU_MEM  out  32  registered ALU result
- mux2Output_MEM  out  5  registered destination register
- err_MEM  out  1  sticky fault flag

## Operation
- FSM states: IDLE, WAIT.
- acc = MemRead_MEM_IN | MemWrite_MEM_IN. aligned = (resALU_MEM_IN[1:0] == 0).
- IDLE, acc & aligned:
  - Latch dmem_addr and dmem_wdata.
  - Set dmem_we = MemWrite_MEM_IN. If both Read and Write are set, the write wins and err_MEM is set.
  - Set dmem_req = 1, clear counter, go to WAIT.
  - stall_MEM = 1. MEM/WB register loads a bubble (WB_MEM = 00, other fields 0).
- IDLE, acc & !aligned: no request, no stall, err_MEM is set, MEM/WB loads the instruction with WB_MEM forced to 00.
- IDLE, !acc: MEM/WB loads WB_MEM_IN, resALU_MEM_IN, mux2Output_MEM_IN, and readData_MEM = 0.
- WAIT, dmem_ack = 1:
  - Drop dmem_req and return to IDLE.
  - stall_MEM = 0 this cycle, so BF2 advances.
  - MEM/WB loads WB_MEM_IN and resALU/mux2Output; readData_MEM = dmem_rdata on a read, 0 on a write.
- WAIT, no ack:
  - stall_MEM = 1, counter increments, MEM/WB loads a bubble.
  - When counter = TIMEOUT-1: abort, drop dmem_req, return to IDLE, set err_MEM, stall_MEM = 0, load the instruction with WB_MEM = 00 and readData 0.
  - A late dmem_ack arriving in IDLE is ignored.
- PC redirect, evaluated only in IDLE:
  - jump_MEM_IN → pcSrc 10, target concatenador_MEM_IN.
  - Otherwise, branch_MEM_IN & zf_MEM_IN → pcSrc 01, target {24'b0, resAdd1_MEM_IN}.
  - Otherwise pcSrc 00, target 0.
  - Jump has priority over branch. In WAIT, pcSrc is 00.
- err_MEM is cleared only by reset.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, WB_MEM 00, readData/resALU/mux2Output 0, err_MEM 0. Reset during WAIT abandons the access with no ack required.
- Non-memory instruction: MEM/WB outputs valid one edge after it is presented; no stall.
- Load/store: cycle 0 detect (stall); dmem_req high from cycle 1; ack at cycle k≥1 → MEM/WB valid after edge k; total stall k cycles.
- dmem_req, dmem_we, dmem_addr and dmem_wdata are stable throughout WAIT.
- An ack in the same cycle as the timeout count is treated as a completion, not a timeout.

## Test plan
- Reset release, then R-type with resALU=0x0000_0042, WB=10, rd=5 → next edge WB_MEM=10, resALU_MEM=0x42, mux2Output=5, readData=0, stall never high.
- Load at resALU=0x0000_0010, memory acks 3 cycles after req with 0xDEAD_BEEF → dmem_addr=0x04, dmem_we=0, stall high 3 cycles, then readData_MEM=0xDEADBEEF with WB_MEM=WB_MEM_IN; preceding bubbles have WB_MEM=00.
- Store at 0x0000_0008, data 0x1234_5678, immediate ack → dmem_we=1, dmem_addr=0x02, dmem_wdata=0x12345678, one stall cycle, err_MEM=0.
- Misaligned load at 0x0000_0013 → dmem_req stays 0, no stall, err_MEM=1, WB_MEM=00; never ack with TIMEOUT=16 → abort after 16 WAIT cycles, err_MEM=1, stall releases.
- jump=1, branch=1, zf=1, concatenador=0x0040_0100 → pcSrc=10, target 0x00400100; branch=1, zf=1, resAdd1=0x2C → pcSrc=01, target 0x2C; zf=0 → pcSrc=00.
- Assert rst_n_MEM low during WAIT → dmem_req drops immediately, all outputs return to reset values; first access after release behaves normally.
